// File: rtl/state_reader_pkg.sv
// Shared permutation-state parameters and the state-reader FSM encoding.
package state_reader_pkg;

    localparam int unsigned LINEW = 25;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_e;

endpackage

// File: rtl/state_reader_line_fifo2.sv
// Two-entry line FIFO carrying a data word plus a last-line flag.
module line_fifo2 #(
    parameter int unsigned W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data,
    output logic         head_last
);

    logic [W-1:0] data_q [2];
    logic [W-1:0] data_d [2];
    logic [1:0]   last_q, last_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];

    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Simultaneous push and pop leaves the count unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '{default: '0};
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/state_reader.sv
// Streams the whole state memory out, line 0..DEPTH-1, through a 2-entry FIFO
// with one-line-per-cycle throughput and outReady backpressure.
module state_reader
    import state_reader_pkg::*;
#(
    parameter int unsigned LINEW = state_reader_pkg::LINEW,
    parameter int unsigned DEPTH = state_reader_pkg::DEPTH,
    parameter int unsigned AW    = state_reader_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [AW-1:0]    memAddr,
    output logic             memRead,
    input  logic [LINEW-1:0] memData,
    output logic [LINEW-1:0] outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             outLast,
    output logic             busy,
    output logic             done
);

    rd_state_e        state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic             fifo_full, fifo_empty, head_last, pop, rd_en, addr_is_last;
    logic [LINEW-1:0] head_data;
    logic [1:0]       occupancy;

    assign occupancy    = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign pop          = ~fifo_empty & outReady;
    assign addr_is_last = (addr_q == AW'(DEPTH - 1));

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rd_en           = 1'b0;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: begin
                // occupancy + inflight - pop < 2, rearranged to stay unsigned
                if (({1'b0, occupancy} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop})) begin
                    rd_en           = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = addr_is_last;
                    addr_d          = addr_is_last ? '0 : addr_q + AW'(1);
                    if (addr_is_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    line_fifo2 #(.W(LINEW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (memData),
        .push_last (inflight_last_q),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign memAddr  = addr_q;
    assign memRead  = rd_en;
    assign outValid = ~fifo_empty;
    assign outData  = head_data;
    assign outLast  = ~fifo_empty & head_last;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);

endmodule

// File: tb/tb_state_reader.sv
// Scoreboard bench: each start queues the full memory image, a negedge monitor
// pops on every transfer; backpressure, restart and reset scenarios.
module tb_state_reader;

    localparam int unsigned LINEW = 25;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    logic             clk = 1'b0;
    logic             rst, start, memRead, outValid, outReady, outLast, busy, done;
    logic [AW-1:0]    memAddr;
    logic [LINEW-1:0] memData, outData;

    always #5 clk = ~clk;

    state_reader #(.LINEW(LINEW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .memAddr  (memAddr),
        .memRead  (memRead),
        .memData  (memData),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .outLast  (outLast),
        .busy     (busy),
        .done     (done)
    );

    // State memory: one-cycle read latency, garbage when not read
    logic [LINEW-1:0] mem [DEPTH];
    always @(posedge clk) memData <= memRead ? mem[memAddr] : LINEW'($urandom);

    typedef struct packed {
        logic [LINEW-1:0] d;
        logic             last;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               checks = 0, failures = 0, cyc = 0;
    int               ready_mode = 0, stall_until = 0, start_cyc = 0;
    int               run_xfers = 0, run_dones = 0, reads_cnt = 0, exp_addr = 0;
    int               first_xfer_cyc = 0, last_xfer_cyc = 0, done_cyc = 0;
    logic             prev_stall = 1'b0;
    logic [LINEW-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer backpressure patterns
    initial begin
        outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       outReady = 1'b1;
                1:       outReady = ~outReady;
                2:       outReady = ($urandom_range(0, 3) != 0);
                default: outReady = (cyc >= stall_until);
            endcase
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_outputs", {memAddr, memRead, outData, outValid, outLast, busy, done}, 0);
                prev_stall = 1'b0;
                exp_addr   = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", outValid, 1);
                    check("hold_data", outData, prev_data);
                end
                if (memRead) begin
                    check("rd_addr", memAddr, exp_addr);
                    exp_addr++;
                    reads_cnt++;
                end
                if (outValid && outReady) begin
                    if (sb.size() == 0) begin
                        check("unexpected_xfer", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("out_data", outData, mon_e.d);
                        check("out_last", outLast, mon_e.last);
                    end
                    if (run_xfers == 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                    run_xfers++;
                end
                if (done) begin
                    check("done_after_all", run_xfers, DEPTH);
                    run_dones++;
                    done_cyc = cyc;
                end
                prev_stall = outValid && !outReady;
                prev_data  = outData;
            end
        end
    end

    task automatic fill_mem(input bit fixed);
        for (int i = 0; i < DEPTH; i++)
            mem[i] = fixed ? LINEW'(i * 3 + 1) : LINEW'($urandom);
    endtask

    task automatic issue_start();
        exp_t e;
        @(posedge clk);
        #1;
        start     = 1'b1;
        run_xfers = 0;
        run_dones = 0;
        reads_cnt = 0;
        exp_addr  = 0;
        start_cyc = cyc;
        for (int i = 0; i < DEPTH; i++) begin
            e.d    = mem[i];
            e.last = (i == DEPTH - 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (run_dones == 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", (run_dones != 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check("one_done", run_dones, 1);
        check("all_lines", run_xfers, DEPTH);
        check("sb_empty", sb.size(), 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        fill_mem(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Full-rate readout with fixed image, latency and throughput
        ready_mode = 0;
        issue_start();
        check("rd_cycle1", {memRead, memAddr}, {1'b1, 6'd0});
        check("busy_cycle1", busy, 1);
        wait_done();
        check("lat_first", first_xfer_cyc - start_cyc, 3);
        check("lat_last", last_xfer_cyc - start_cyc, 3 + DEPTH - 1);
        check("lat_done", done_cyc - start_cyc, 3 + DEPTH);

        // Consumer stalled for 10 cycles after start
        fill_mem(1'b0);
        ready_mode  = 3;
        stall_until = 32'h3fff_ffff;
        issue_start();
        stall_until = start_cyc + 11;
        repeat (8) @(posedge clk);
        #1;
        check("stall_reads", reads_cnt, 2);
        check("stall_valid", outValid, 1);
        check("stall_data", outData, mem[0]);
        wait_done();

        // Alternating outReady
        fill_mem(1'b0);
        ready_mode = 1;
        issue_start();
        wait_done();

        // start re-asserted while busy
        fill_mem(1'b0);
        ready_mode = 2;
        issue_start();
        while (cyc < start_cyc + 20) @(posedge clk);
        #1;
        check("busy_at_restart", busy, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Reset in the middle of a transfer, then a clean restart
        fill_mem(1'b0);
        ready_mode = 2;
        issue_start();
        n = 0;
        while (run_xfers < 30 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("xfer30_timeout", (run_xfers >= 30), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {memAddr, memRead, outData, outValid, outLast, busy, done}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        reads_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        check("no_read_without_start", reads_cnt, 0);
        check("idle_after_rst", {busy, outValid}, 0);
        issue_start();
        wait_done();

        // Random images under random backpressure
        for (int r = 0; r < 3; r++) begin
            fill_mem(1'b0);
            ready_mode = 2;
            issue_start();
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/state_reader.md
STATE_READER -- requirements
Module: state_reader

Interface
REQ-001 Parameter LINEW, default 25, width of one state slice line in bits (5x5 lanes).
REQ-002 Parameter DEPTH, default 64, number of slice lines in state memory.
REQ-003 Parameter AW, default 6, address width (DEPTH <= 2^AW).
REQ-004 clk  in  1  clock, rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to read out the whole state after permutation completes.
REQ-007 memAddr  out  AW  state memory line address.
REQ-008 memRead  out  1  read strobe; memData is valid exactly one cycle after memRead.
REQ-009 memData  in  LINEW  line returned by state memory.
REQ-010 outData  out  LINEW  streamed line.
REQ-011 outValid  out  1  outData valid.
REQ-012 outReady  in  1  consumer accepts; a transfer occurs on outValid & outReady.
REQ-013 outLast  out  1  high with the line at address DEPTH-1.
REQ-014 busy  out  1  high from the cycle after start is accepted until the done cycle.
REQ-015 done  out  1  one-cycle pulse after the last transfer.

Function
REQ-016 The FSM SHALL have the states Idle, Fetch, Drain and Finish; Idle -> Fetch on start; Fetch -> Drain when address DEPTH-1 is issued; Drain -> Finish on the outLast transfer; Finish -> Idle unconditionally.
REQ-017 start SHALL be ignored outside Idle.
REQ-018 Lines SHALL be read in ascending order 0..DEPTH-1, each exactly once, with memAddr incremented only when a read is issued.
REQ-019 A 2-entry FIFO SHALL hold returned lines; memData SHALL be written into it in the cycle after memRead.
REQ-020 memRead SHALL be asserted in Fetch only when occupancy + inflight - pop < 2 (inflight = read issued in the previous cycle; pop = outValid & outReady); the FIFO SHALL never overflow and no line SHALL be dropped.
REQ-021 outValid SHALL equal "FIFO non-empty"; outData/outLast SHALL come from the FIFO head and SHALL stay stable while outValid & ~outReady.
REQ-022 Latency: start high in cycle 0 -> memRead with addr 0 in cycle 1 -> outValid with line 0 in cycle 3.
REQ-023 With outReady held high, throughput SHALL be one line per cycle.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged; the FIFO pointers SHALL wrap modulo 2.
REQ-025 done SHALL pulse in the Finish cycle, and busy SHALL deassert in the following cycle.
REQ-026 An outReady toggle in any cycle SHALL neither alter order nor duplicate a line.

Reset
REQ-027 rst SHALL force state Idle and clear the address counter, the FIFO pointers and the inflight flag.
REQ-028 During rst all outputs SHALL be 0 (memAddr, memRead, outData, outValid, outLast, busy, done).
REQ-029 rst mid-transfer SHALL abort the transfer; a new start is required to re-read from line 0.

Structure
REQ-030 LINEW, DEPTH, AW and the state encoding (2-bit) SHALL reside in the shared permutation package used by the permutation controller.
REQ-031 The 2-entry FIFO SHALL be a sub-module named line_fifo2 (push, pop, full, empty, head data + last flag).

Verification
REQ-032 Memory preloaded with line i = i*3+1; start pulse, outReady=1 -> outValid in cycle 3, lines 1,4,...,190 on consecutive cycles, outLast on 190, done in the following cycle.
REQ-033 outReady=0 for 10 cycles after start -> at most 2 reads issued (addr 0,1), outData=1 held stable, then release -> all 64 lines in order.
REQ-034 outReady alternating 1/0 each cycle -> exactly 64 transfers, no duplicates, done once.
REQ-035 start re-asserted in cycle 20 while busy -> ignored; exactly 64 lines and one done.
REQ-036 rst asserted at transfer 30 -> all outputs 0 at once; a subsequent start restarts at address 0 and delivers all 64 lines.
